wb_master_guard: RTL and testbench

- Per-master protection stage placed directly upstream of one data bus master port (between a bus master, e.g. CPU data port or DMA, and the 3-to-1 arbiter input).
- Limits outstanding pipelined Wishbone requests.
- Enforces a response timeout; when it fires, aborts the downstream cycle and returns err to the master so a dead slave cannot lock the bus.
- Zero-latency pass-through in normal operation.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_guard_timer.sv | 49 ++++
 rtl/wb_master_guard.sv | 196 +++++++++++++++++++
 tb/tb_wb_master_guard.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// +------------------------------------------------------------------+
// | wb_pkg: shared types for the Wishbone master guard               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    ABORT   = 2'd2,
    RELEASE = 2'd3
  } guard_state_t;

  // States in which the master is connected straight through to the bus.
  function automatic logic guard_is_live(input guard_state_t s);
    return (s == IDLE) || (s == ACTIVE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_guard_timer.sv
// +------------------------------------------------------------------+
// | wb_guard_timer: loadable saturating cycle counter with expiry    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module wb_guard_timer #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != c_limit)) begin
      count_d = count_q + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == c_limit);

endmodule

`default_nettype wire

// File: rtl/wb_master_guard.sv
// +------------------------------------------------------------------+
// | wb_master_guard: outstanding-request limiter and response        |
// | timeout for one pipelined Wishbone master port                   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module wb_master_guard
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_cyc,
  input  logic                    s_stb,
  input  logic                    s_we,
  input  logic [ADDR_WIDTH-1:0]   s_adr,
  input  logic [DATA_WIDTH-1:0]   s_dat_w,
  input  logic [SELECT_WIDTH-1:0] s_sel,
  output logic [DATA_WIDTH-1:0]   s_dat_r,
  output logic                    s_ack,
  output logic                    s_err,
  output logic                    s_stall,
  output logic                    m_cyc,
  output logic                    m_stb,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_adr,
  output logic [DATA_WIDTH-1:0]   m_dat_w,
  output logic [SELECT_WIDTH-1:0] m_sel,
  input  logic [DATA_WIDTH-1:0]   m_dat_r,
  input  logic                    m_ack,
  input  logic                    m_err,
  input  logic                    m_stall,
  output logic                    timeout_pulse,
  output logic [ADDR_WIDTH-1:0]   timeout_adr
);

  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  guard_state_t          state_q;
  guard_state_t          state_d;
  logic [c_cnt_w-1:0]    outstanding_q;
  logic [c_cnt_w-1:0]    outstanding_d;
  logic [ADDR_WIDTH-1:0] last_adr_q;
  logic [ADDR_WIDTH-1:0] last_adr_d;
  logic [ADDR_WIDTH-1:0] timeout_adr_q;
  logic [ADDR_WIDTH-1:0] timeout_adr_d;

  logic               w_live;
  logic               w_has_out;
  logic               w_full;
  logic               w_fire;
  logic               w_block;
  logic               w_accept;
  logic               w_resp;
  logic               w_timer_clr;
  logic               w_timer_en;
  logic               w_timer_expired;
  logic [c_cnt_w-1:0] w_cnt_step;

  assign m_adr   = s_adr;
  assign m_dat_w = s_dat_w;
  assign m_sel   = s_sel;
  assign m_we    = s_we;
  assign s_dat_r = m_dat_r;

  assign w_live    = guard_is_live(state_q);
  assign w_has_out = (outstanding_q != '0);
  assign w_full    = (outstanding_q == c_cnt_max);
  // The firing cycle also blocks, so a strobe racing the timeout is never accepted.
  assign w_fire    = (state_q == ACTIVE) & s_cyc & w_timer_expired;
  assign w_block   = w_full | w_fire;

  assign w_accept   = s_cyc & s_stb & ~s_stall;
  assign w_resp     = w_live & (m_ack | m_err) & w_has_out;
  assign w_cnt_step = outstanding_q + c_cnt_w'(w_accept) - c_cnt_w'(w_resp);

  assign w_timer_clr = (state_q != ACTIVE) | ~s_cyc | w_accept | w_resp;
  assign w_timer_en  = s_cyc & (w_has_out | s_stb);

  assign timeout_pulse = w_fire;
  assign timeout_adr   = w_fire ? last_adr_q : timeout_adr_q;

  wb_guard_timer #(
    .WIDTH (c_tmr_w),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_timer_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (w_timer_en),
    .expired  (w_timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    last_adr_d    = w_accept ? s_adr : last_adr_q;
    timeout_adr_d = w_fire ? last_adr_q : timeout_adr_q;
    case (state_q)
      IDLE: begin
        outstanding_d = w_cnt_step;
        if (s_cyc) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Dropping cyc abandons every response still in flight.
        if (!s_cyc) begin
          state_d       = IDLE;
          outstanding_d = '0;
        end else begin
          outstanding_d = w_cnt_step;
          if (w_fire) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        // An empty counter on entry still yields one err for the stalled strobe.
        if (outstanding_q <= c_cnt_one) begin
          state_d = RELEASE;
        end
        if (w_has_out) begin
          outstanding_d = outstanding_q - c_cnt_one;
        end
      end
      RELEASE: begin
        if (!s_cyc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    s_stall = 1'b1;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE, ACTIVE: begin
          m_cyc   = s_cyc;
          m_stb   = s_stb & ~w_block;
          s_stall = m_stall | w_block;
          s_ack   = m_ack & w_has_out;
          s_err   = m_err & w_has_out;
        end
        ABORT: begin
          s_err = 1'b1;
        end
        default: begin
          s_err = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      last_adr_q    <= '0;
      timeout_adr_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      last_adr_q    <= last_adr_d;
      timeout_adr_q <= timeout_adr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_guard.sv
// +------------------------------------------------------------------+
// | tb_wb_master_guard: randomized scoreboard bench for the guard    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_wb_master_guard;

  localparam int MAX = 4;
  localparam int T   = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_ABORT = 2;
  localparam int M_REL   = 3;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        is_err;
  } slv_t;

  logic        clk;
  logic        rst_n;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_stall;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_w, m_dat_r;
  logic [3:0]  m_sel;
  logic        m_ack, m_err, m_stall;
  logic        timeout_pulse;
  logic [31:0] timeout_adr;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  slv_t sq[$];

  // Reference model: request count, quiet-cycle count and phase of the guard.
  int          mode = M_IDLE;
  int          n = 0;
  int          quiet = 0;
  int          cyc_no = 0;
  logic [31:0] last_acc = '0;
  logic [31:0] tadr = '0;
  logic        accepted;

  // Stimulus knobs.
  logic [31:0] cur_adr = 32'h0, cur_dat = 32'h0;
  logic [3:0]  cur_sel = 4'hF;
  logic        cur_we = 1'b0;
  int          lat_min = 1, lat_max = 1;
  logic        dead = 0, dead_stall = 0, stall_rand = 0, err_rand = 0;
  logic        gap_rand = 0, rand_we = 0, inject_late = 0;
  logic        fixed_en = 0;
  logic [31:0] fixed_data = '0;

  wb_master_guard #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .SELECT_WIDTH    (4),
    .MAX_OUTSTANDING (MAX),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_cyc         (s_cyc),
    .s_stb         (s_stb),
    .s_we          (s_we),
    .s_adr         (s_adr),
    .s_dat_w       (s_dat_w),
    .s_sel         (s_sel),
    .s_dat_r       (s_dat_r),
    .s_ack         (s_ack),
    .s_err         (s_err),
    .s_stall       (s_stall),
    .m_cyc         (m_cyc),
    .m_stb         (m_stb),
    .m_we          (m_we),
    .m_adr         (m_adr),
    .m_dat_w       (m_dat_w),
    .m_sel         (m_sel),
    .m_dat_r       (m_dat_r),
    .m_ack         (m_ack),
    .m_err         (m_err),
    .m_stall       (m_stall),
    .timeout_pulse (timeout_pulse),
    .timeout_adr   (timeout_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // Scoreboard monitor: every response seen at the master port consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (s_ack || s_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: ack=%0b err=%0b with no response expected (cycle %0d)",
                 s_ack, s_err, cyc_no);
      end else begin
        e = exp_q.pop_front();
        if ((s_ack && s_err) || (s_err != e.is_err) || (!e.is_err && s_dat_r != e.data)) begin
          errors++;
          $display("FAIL resp: got ack=%0b err=%0b data=%h expected err=%0b data=%h (cycle %0d)",
                   s_ack, s_err, s_dat_r, e.is_err, e.data, cyc_no);
        end
      end
    end
  end

  task automatic tick(input logic cyc, input logic stb);
    logic        live, fire, blk, exp_stall, acc, rsp, e;
    logic [31:0] d;
    @(posedge clk);
    #1;
    cyc_no++;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    m_dat_r = $urandom;
    if (mode == M_ABORT && inject_late) begin
      m_ack = 1'b1;
      m_err = 1'($urandom_range(0, 1));
    end else if (!dead && sq.size() > 0 && sq[0].due <= cyc_no) begin
      m_ack   = !sq[0].is_err;
      m_err   = sq[0].is_err;
      m_dat_r = sq[0].data;
      sq.delete(0);
    end
    m_stall = dead_stall ? 1'b1 : (stall_rand && ($urandom_range(0, 3) == 0));
    s_cyc   = cyc;
    s_stb   = stb;
    s_adr   = cur_adr;
    s_dat_w = cur_dat;
    s_sel   = cur_sel;
    s_we    = cur_we;
    #1;

    live      = (mode == M_IDLE) || (mode == M_RUN);
    fire      = (mode == M_RUN) && cyc && (quiet == T - 1);
    blk       = !live || (n == MAX) || fire;
    exp_stall = blk || m_stall;
    acc       = cyc && stb && !exp_stall;
    rsp       = live && (m_ack || m_err) && (n > 0);

    chk("s_stall", s_stall, exp_stall);
    chk("m_cyc", m_cyc, live && cyc);
    chk("m_stb", m_stb, live && stb && !blk);
    chk("timeout_pulse", timeout_pulse, fire);
    chk("timeout_adr", timeout_adr, fire ? last_acc : tadr);
    chk("pass_fwd", {m_adr, m_dat_w, m_sel, m_we}, {cur_adr, cur_dat, cur_sel, cur_we});
    chk("pass_rdata", s_dat_r, m_dat_r);

    accepted = acc;
    if (acc) begin
      last_acc = cur_adr;
      if (dead) begin
        exp_q.push_back('{is_err: 1'b1, data: 32'h0});
      end else begin
        d = fixed_en ? fixed_data : $urandom;
        e = err_rand && ($urandom_range(0, 4) == 0);
        sq.push_back('{due: cyc_no + $urandom_range(lat_min, lat_max), data: d, is_err: e});
        exp_q.push_back('{is_err: e, data: d});
      end
      cur_adr = $urandom & 32'hFFFF_FFFC;
      cur_dat = $urandom;
      cur_sel = 4'($urandom_range(1, 15));
      if (rand_we) cur_we = 1'($urandom_range(0, 1));
    end
    if (fire) tadr = last_acc;

    case (mode)
      M_IDLE: begin
        n = n + int'(acc);
        quiet = 0;
        if (cyc) mode = M_RUN;
      end
      M_RUN: begin
        if (!cyc) begin
          mode = M_IDLE;
          n = 0;
          quiet = 0;
        end else if (fire) begin
          n = n - int'(rsp);
          quiet = 0;
          mode = M_ABORT;
          if (n == 0) exp_q.push_back('{is_err: 1'b1, data: 32'h0});
        end else begin
          if (acc || rsp) quiet = 0;
          else if ((n > 0 || stb) && quiet < T - 1) quiet++;
          n = n + int'(acc) - int'(rsp);
        end
      end
      M_ABORT: begin
        if (n <= 1) mode = M_REL;
        if (n > 0) n--;
      end
      default: begin
        if (!cyc) mode = M_IDLE;
      end
    endcase
  endtask

  task automatic burst(input int count);
    int   left;
    int   k;
    logic stb;
    left = count;
    k = 0;
    while (!((left == 0 && n == 0 && mode != M_ABORT) || mode == M_REL) && k < 400) begin
      stb = (left > 0) && (!gap_rand || $urandom_range(0, 3) != 0);
      tick(1'b1, stb);
      if (accepted) left--;
      k++;
    end
    if (k >= 400) begin
      checks++;
      errors++;
      $display("FAIL burst_budget: %0d requests left after %0d cycles", left, k);
    end
    if (mode == M_REL) repeat (3) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("responses_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_cyc   = 1'b1;
    s_stb   = 1'b1;
    s_we    = 1'b0;
    s_adr   = 32'h0000_1234;
    s_dat_w = '0;
    s_sel   = 4'hF;
    m_dat_r = '0;
    m_ack   = 1'b1;
    m_err   = 1'b1;
    m_stall = 1'b0;
    #12;
    chk("reset_m_cyc", m_cyc, 0);
    chk("reset_m_stb", m_stb, 0);
    chk("reset_s_ack", s_ack, 0);
    chk("reset_s_err", s_err, 0);
    chk("reset_s_stall", s_stall, 1);
    chk("reset_pulse", timeout_pulse, 0);
    chk("reset_tadr", timeout_adr, 0);
    @(negedge clk);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    m_ack = 1'b0;
    m_err = 1'b0;
    rst_n = 1'b1;

    // Single read, three-cycle slave.
    fixed_en = 1; fixed_data = 32'hDEAD_BEEF;
    lat_min = 3; lat_max = 3;
    cur_adr = 32'h0000_0010; cur_we = 0;
    burst(1);
    fixed_en = 0;

    // Six reads against a slow slave: limiter holds at four.
    lat_min = 8; lat_max = 8;
    burst(6);

    // Dead slave on a write.
    dead = 1;
    cur_adr = 32'h1000_0000; cur_we = 1;
    burst(1);

    // Three outstanding then timeout, with late acks during the abort.
    cur_we = 0;
    inject_late = 1;
    burst(3);
    inject_late = 0;
    dead = 0;

    // Steady accept+ack at two outstanding.
    lat_min = 2; lat_max = 2;
    burst(24);

    // Reset with two requests in flight.
    lat_min = 10; lat_max = 10;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_cyc", m_cyc, 0);
    chk("midrst_m_stb", m_stb, 0);
    chk("midrst_s_stall", s_stall, 1);
    mode = M_IDLE; n = 0; quiet = 0; last_acc = '0; tadr = '0;
    sq.delete();
    exp_q.delete();
    @(negedge clk);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat_min = 3; lat_max = 3;
    burst(1);

    // Strobe stalled forever by the bus with nothing outstanding.
    dead = 1; dead_stall = 1;
    burst(1);
    dead = 0; dead_stall = 0;

    // Randomized traffic.
    stall_rand = 1; err_rand = 1; gap_rand = 1; rand_we = 1;
    for (int i = 0; i < 30; i++) begin
      lat_min = 1;
      lat_max = $urandom_range(1, 6);
      dead = ($urandom_range(0, 5) == 0);
      burst($urandom_range(1, 8));
    end
    stall_rand = 0; err_rand = 0; gap_rand = 0; rand_we = 0; dead = 0;

    repeat (3) tick(1'b0, 1'b0);
    chk("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
